// File: rtl/irq_entry_seq.sv
// MSP430 interrupt entry sequencer: arbitrates maskable requests at an instruction
// boundary, then pushes PC/SR, clears SR, fetches the vector and loads PC.
// Optional build macro IRQ_NMI_EN adds an edge-triggered non-maskable request.
module irq_entry_seq #(
  parameter int          NUM_IRQ  = 8,
  parameter logic [15:0] VEC_BASE = 16'hFFE0
) (
  input  logic               clk,
  input  logic               rst,
`ifdef IRQ_NMI_EN
  input  logic               nmi,
`endif
  input  logic [NUM_IRQ-1:0] irq_req,
  output logic [NUM_IRQ-1:0] irq_ack,
  input  logic               instr_boundary,
  input  logic [15:0]        pc_in,
  input  logic [15:0]        sr_in,
  input  logic [15:0]        sp_in,
  output logic               cpu_hold,
  output logic               pc_wr,
  output logic               sr_wr,
  output logic               sp_wr,
  output logic [15:0]        pc_next,
  output logic [15:0]        sr_next,
  output logic [15:0]        sp_next,
  output logic [15:0]        mem_addr,
  output logic [15:0]        mem_wdata,
  output logic               mem_we,
  output logic               mem_re,
  input  logic [15:0]        mem_rdata,
  input  logic               mem_rdy
);
  localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_PUSH_PC  = 2'd1;
  localparam logic [1:0] S_PUSH_SR  = 2'd2;
  localparam logic [1:0] S_READ_VEC = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q, win_idx;
  logic [15:0]   pc_q, sr_q, sp_q, vec_addr;
  logic          nmi_svc_q, nmi_pend, grant, done;

  // Ascending scan: the last (highest) set index wins.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_IRQ; i++)
      if (irq_req[i]) win_idx = IW'(i);
  end

  assign grant = (state_q == S_IDLE) && instr_boundary &&
                 (nmi_pend || (sr_in[3] && |irq_req));
  assign done  = (state_q == S_READ_VEC) && mem_rdy;

`ifdef IRQ_NMI_EN
  logic nmi_q, nmi_pend_q, nmi_repend_q, nmi_edge;
  assign nmi_edge = nmi & ~nmi_q;
  assign nmi_pend = nmi_pend_q;

  // The pending flag stays up during its own sequence, so a fresh edge seen
  // meanwhile is remembered separately and re-arms the flag at completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nmi_q        <= 1'b0;
      nmi_pend_q   <= 1'b0;
      nmi_repend_q <= 1'b0;
    end else begin
      nmi_q <= nmi;
      if (done && nmi_svc_q) begin
        nmi_pend_q   <= nmi_edge | nmi_repend_q;
        nmi_repend_q <= 1'b0;
      end else begin
        nmi_pend_q <= nmi_pend_q | nmi_edge;
        if (nmi_edge && nmi_svc_q && state_q != S_IDLE) nmi_repend_q <= 1'b1;
      end
    end
  end
`else
  assign nmi_pend = 1'b0;
`endif

  assign vec_addr = nmi_svc_q ? 16'hFFFC : VEC_BASE + (16'(idx_q) << 1);
  assign cpu_hold = (state_q != S_IDLE);

  always_comb begin
    state_d   = state_q;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    sp_wr     = 1'b0;
    sp_next   = '0;
    sr_wr     = 1'b0;
    sr_next   = '0;
    pc_wr     = 1'b0;
    pc_next   = '0;
    irq_ack   = '0;
    case (state_q)
      S_IDLE: if (grant) state_d = S_PUSH_PC;
      S_PUSH_PC: begin
        mem_we    = 1'b1;
        mem_addr  = sp_q - 16'd2;
        mem_wdata = pc_q;
        if (mem_rdy) begin
          sp_wr   = 1'b1;
          sp_next = sp_q - 16'd2;
          state_d = S_PUSH_SR;
        end
      end
      S_PUSH_SR: begin
        mem_we    = 1'b1;
        mem_addr  = sp_q - 16'd4;
        mem_wdata = sr_q;
        if (mem_rdy) begin
          sp_wr   = 1'b1;
          sp_next = sp_q - 16'd4;
          sr_wr   = 1'b1;
          sr_next = sr_q & 16'h0040;
          state_d = S_READ_VEC;
        end
      end
      default: begin
        mem_re   = 1'b1;
        mem_addr = vec_addr;
        if (mem_rdy) begin
          pc_wr   = 1'b1;
          pc_next = mem_rdata & 16'hFFFE;
          for (int i = 0; i < NUM_IRQ; i++)
            irq_ack[i] = !nmi_svc_q && (idx_q == IW'(i));
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      pc_q      <= '0;
      sr_q      <= '0;
      sp_q      <= '0;
      nmi_svc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        idx_q     <= win_idx;
        pc_q      <= pc_in;
        sr_q      <= sr_in;
        sp_q      <= sp_in & 16'hFFFE;
        nmi_svc_q <= nmi_pend;
      end
    end
  end
endmodule

// File: tb/tb_irq_entry_seq.sv
// Randomized self-checking bench for irq_entry_seq; expectations come from the
// push/vector arithmetic of the entry sequence applied to the driven values.
module tb_irq_entry_seq;
  localparam int N = 8;
  localparam logic [15:0] VB = 16'hFFE0;

  logic clk = 1'b0, rst = 1'b0;
  logic nmi = 1'b0;
  logic [N-1:0] irq_req = '0, irq_ack;
  logic instr_boundary = 1'b0;
  logic [15:0] pc_in = '0, sr_in = '0, sp_in = '0;
  logic cpu_hold, pc_wr, sr_wr, sp_wr, mem_we, mem_re;
  logic [15:0] pc_next, sr_next, sp_next, mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic mem_rdy = 1'b0;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  irq_entry_seq #(.NUM_IRQ(N), .VEC_BASE(VB)) dut (
    .clk(clk), .rst(rst),
`ifdef IRQ_NMI_EN
    .nmi(nmi),
`endif
    .irq_req(irq_req), .irq_ack(irq_ack), .instr_boundary(instr_boundary),
    .pc_in(pc_in), .sr_in(sr_in), .sp_in(sp_in), .cpu_hold(cpu_hold),
    .pc_wr(pc_wr), .sr_wr(sr_wr), .sp_wr(sp_wr),
    .pc_next(pc_next), .sr_next(sr_next), .sp_next(sp_next),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .mem_rdy(mem_rdy)
  );

  function automatic int highest(input logic [N-1:0] r);
    for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
    return -1;
  endfunction

  // One full entry: grant cycle, then three stages with w[s] wait cycles each.
  // vec_override>=0 forces the expected vector address (NMI); drop_stage clears irq_req.
  task automatic run_entry(input logic [15:0] pc, sp, sr, input logic [N-1:0] req,
                           input int w0, w1, w2, input logic [15:0] vdata,
                           input int drop_stage, input int vec_override);
    int idx, w;
    logic [15:0] spa, ea, ed;
    logic last;
    logic [N-1:0] eack;
    idx = highest(req);
    spa = sp & 16'hFFFE;
    @(negedge clk);
    irq_req = req; pc_in = pc; sp_in = sp; sr_in = sr;
    instr_boundary = 1'b1; mem_rdy = 1'b0;
    #1;
    checks++;
    if (cpu_hold !== 1'b0 || mem_we !== 1'b0)
      begin failures++; $display("FAIL grant_cycle hold=%b we=%b want 0 0", cpu_hold, mem_we); end
    for (int s = 0; s < 3; s++) begin
      w = (s == 0) ? w0 : (s == 1) ? w1 : w2;
      for (int k = 0; k <= w; k++) begin
        @(negedge clk);
        instr_boundary = 1'b0;
        if (s == drop_stage) irq_req = '0;
        last = (k == w);
        mem_rdy = last;
        mem_rdata = last ? vdata : 16'($urandom);
        #1;
        case (s)
          0: begin ea = spa - 16'd2; ed = pc; end
          1: begin ea = spa - 16'd4; ed = sr; end
          default: begin
            ea = (vec_override >= 0) ? 16'(vec_override) : VB + 16'(2 * idx);
            ed = 16'h0000;
          end
        endcase
        eack = (last && s == 2 && vec_override < 0) ? N'(1) << idx : '0;
        checks++;
        if (cpu_hold !== 1'b1)
          begin failures++; $display("FAIL hold s%0d k%0d got %b want 1", s, k, cpu_hold); end
        checks++;
        if (mem_addr !== ea)
          begin failures++; $display("FAIL addr s%0d k%0d got %h want %h", s, k, mem_addr, ea); end
        checks++;
        if (mem_we !== (s < 2) || mem_re !== (s == 2))
          begin failures++; $display("FAIL we_re s%0d got %b%b", s, mem_we, mem_re); end
        if (s < 2) begin
          checks++;
          if (mem_wdata !== ed)
            begin failures++; $display("FAIL wdata s%0d k%0d got %h want %h", s, k, mem_wdata, ed); end
        end
        checks++;
        if (sp_wr !== (last && s < 2) || sr_wr !== (last && s == 1) || pc_wr !== (last && s == 2))
          begin failures++; $display("FAIL strobes s%0d k%0d got sp%b sr%b pc%b", s, k, sp_wr, sr_wr, pc_wr); end
        checks++;
        if (irq_ack !== eack)
          begin failures++; $display("FAIL ack s%0d k%0d got %h want %h", s, k, irq_ack, eack); end
        if (last && s < 2) begin
          checks++;
          if (sp_next !== ea)
            begin failures++; $display("FAIL sp_next s%0d got %h want %h", s, sp_next, ea); end
        end
        if (last && s == 1) begin
          checks++;
          if (sr_next !== (sr & 16'h0040))
            begin failures++; $display("FAIL sr_next got %h want %h", sr_next, sr & 16'h0040); end
        end
        if (last && s == 2) begin
          checks++;
          if (pc_next !== (vdata & 16'hFFFE))
            begin failures++; $display("FAIL pc_next got %h want %h", pc_next, vdata & 16'hFFFE); end
        end
      end
    end
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    instr_boundary = 1'b0; mem_rdy = 1'b1;
    #1;
    checks++;
    if (cpu_hold !== 1'b0 || mem_we !== 1'b0 || mem_re !== 1'b0 || sp_wr !== 1'b0 ||
        sr_wr !== 1'b0 || pc_wr !== 1'b0 || irq_ack !== '0)
      begin failures++; $display("FAIL idle_%s hold=%b we=%b re=%b sp=%b sr=%b pc=%b ack=%h",
                                 tag, cpu_hold, mem_we, mem_re, sp_wr, sr_wr, pc_wr, irq_ack); end
  endtask

  task automatic test_reset;
    rst = 1'b0; mem_rdy = 1'b1; instr_boundary = 1'b1; irq_req = 8'hFF; sr_in = 16'h0008;
    #1;
    checks++;
    if ({cpu_hold, mem_we, mem_re, sp_wr, sr_wr, pc_wr} !== 6'b0 || irq_ack !== '0 || mem_addr !== '0)
      begin failures++; $display("FAIL reset_outputs hold=%b we=%b addr=%h", cpu_hold, mem_we, mem_addr); end
    @(negedge clk); @(negedge clk);
    instr_boundary = 1'b0; irq_req = '0;
    rst = 1'b1;
    idle_check("after_reset");
  endtask

  task automatic test_basic;
    run_entry(16'h4400, 16'h0A00, 16'h0008, 8'h08, 0, 0, 0, 16'hC123, -1, -1);
    idle_check("basic_end");
  endtask

  task automatic test_priority_mask;
    run_entry(16'h1234, 16'h0400, 16'h00F9, 8'h22, 0, 0, 0, 16'h8001, -1, -1);
    idle_check("prio_end");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      irq_req = 8'h22; sr_in = 16'h00F7; instr_boundary = 1'b1; mem_rdy = 1'b1;
      #1;
      checks++;
      if (cpu_hold !== 1'b0 || mem_we !== 1'b0)
        begin failures++; $display("FAIL gie_mask c%0d hold=%b we=%b want 0 0", c, cpu_hold, mem_we); end
    end
    irq_req = '0;
    idle_check("mask_end");
  endtask

  task automatic test_wait_states;
    run_entry(16'hBEEF, 16'h2000, 16'h0048, 8'h81, 2, 2, 2, 16'hF00D, -1, -1);
    idle_check("wait_end");
  endtask

  task automatic test_wrap_deassert;
    run_entry(16'h5555, 16'h0002, 16'h004B, 8'h04, 0, 1, 0, 16'h3333, 1, -1);
    idle_check("wrap_end");
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    irq_req = 8'h01; sr_in = 16'h0008; pc_in = 16'h1000; sp_in = 16'h0300;
    instr_boundary = 1'b1; mem_rdy = 1'b0;
    @(negedge clk); instr_boundary = 1'b0; mem_rdy = 1'b1;
    @(negedge clk); mem_rdy = 1'b1;
    #1;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 16'h02FC)
      begin failures++; $display("FAIL rstmid_pre we=%b addr=%h want 1 02fc", mem_we, mem_addr); end
    rst = 1'b0;
    #1;
    checks++;
    if ({cpu_hold, mem_we, mem_re, sp_wr, sr_wr, pc_wr} !== 6'b0 || mem_addr !== '0 || mem_wdata !== '0)
      begin failures++; $display("FAIL rstmid_outputs hold=%b we=%b sp=%b sr=%b", cpu_hold, mem_we, sp_wr, sr_wr); end
    @(negedge clk); rst = 1'b1; irq_req = '0;
    for (int c = 0; c < 3; c++) idle_check("rstmid_after");
  endtask

  task automatic test_back_to_back;
    run_entry(16'h0100, 16'h0800, 16'h0008, 8'h10, 0, 0, 0, 16'hA000, -1, -1);
    run_entry(16'h0200, 16'h07FC, 16'h0009, 8'h03, 1, 0, 1, 16'hA101, -1, -1);
    idle_check("b2b_end");
  endtask

  task automatic test_random;
    logic [N-1:0] req;
    for (int t = 0; t < 20; t++) begin
      req = N'($urandom_range(1, (1 << N) - 1));
      run_entry(16'($urandom), 16'($urandom), 16'($urandom) | 16'h0008, req,
                $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                16'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1, -1);
      if ($urandom_range(0, 1) == 1) idle_check("rand");
    end
    idle_check("rand_end");
  endtask

`ifdef IRQ_NMI_EN
  task automatic test_nmi;
    @(negedge clk); nmi = 1'b1;
    @(negedge clk); nmi = 1'b0;
    run_entry(16'h7000, 16'h0600, 16'h0000, 8'h80, 0, 0, 0, 16'hD000, -1, 16'hFFFC);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      irq_req = 8'h80; sr_in = 16'h0000; instr_boundary = 1'b1; mem_rdy = 1'b1;
      #1;
      checks++;
      if (cpu_hold !== 1'b0)
        begin failures++; $display("FAIL nmi_then_masked c%0d hold=%b want 0", c, cpu_hold); end
    end
    run_entry(16'h7100, 16'h0600, 16'h0008, 8'h80, 0, 0, 0, 16'hD200, -1, -1);
    idle_check("nmi_end");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_priority_mask();
    test_wait_states();
    test_wrap_deassert();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef IRQ_NMI_EN
    test_nmi();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/irq_entry_seq.md
# irq_entry_seq

Interrupt entry sequencer for the MSP430 core. At an instruction boundary it arbitrates pending maskable interrupt requests and stalls the control unit. It then drives the register-file PC/SP/SR update ports and the data-memory port through the hardware entry sequence: push PC, push SR, clear SR, fetch vector, load PC. It sits beside the control unit, sharing the register file's CPU-register inputs and the memory bus with it, and owns them while active.

## Interface
Parameters:
- NUM_IRQ, 8: number of maskable request lines (1..16).
- VEC_BASE, 16'hFFE0: vector address of request 0; request i vector = VEC_BASE + 2*i.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- irq_req  in  NUM_IRQ  level-sensitive interrupt requests.
- irq_ack  out  NUM_IRQ  one-hot, one-cycle acknowledge of the serviced request.
- instr_boundary  in  1  control unit is between instructions; grant allowed.
- pc_in, sr_in, sp_in  in  16 each  current PC/SR/SP from the register file.
- cpu_hold  out  1  control unit must stall; sequencer owns register/memory ports.
- pc_wr, sr_wr, sp_wr  out  1 each  write strobes for PC/SR/SP.
- pc_next, sr_next, sp_next  out  16 each  values written when the matching strobe is high.
- mem_addr  out  16  word address (bit0 always 0).
- mem_wdata  out  16  write data.
- mem_we, mem_re  out  1 each  write/read request; held until mem_rdy.
- mem_rdata  in  16  read data, valid with mem_rdy.
- mem_rdy  in  1  access complete this cycle.

## Operation
- States: IDLE, PUSH_PC, PUSH_SR, READ_VEC.
- Grant in IDLE when instr_boundary && sr_in[3] (GIE) && |irq_req.
- Priority: the highest set index wins.
- At grant, latch idx, pc_in, sr_in, and sp_in & 16'hFFFE. Next state is PUSH_PC.
- PUSH_PC:
  - Drive mem_we=1, mem_addr=sp-2, mem_wdata=pc.
  - On mem_rdy: pulse sp_wr with sp_next=sp-2 and go to PUSH_SR.
- PUSH_SR:
  - Drive mem_we=1, mem_addr=sp-4, mem_wdata=latched SR.
  - On mem_rdy: pulse sp_wr with sp_next=sp-4. Pulse sr_wr with sr_next = latched SR & 16'h0040 (clears GIE/CPUOFF/OSCOFF/SCG1, keeps SCG0). Go to READ_VEC.
- READ_VEC:
  - Drive mem_re=1, mem_addr=VEC_BASE+2*idx.
  - On mem_rdy: pulse pc_wr with pc_next = mem_rdata & 16'hFFFE, pulse irq_ack[idx], and return to IDLE.
- cpu_hold=1 in every state except IDLE.
- Strobes are zero whenever their condition does not hold.
- SP arithmetic is modulo 2^16: sp=16'h0002 yields push addresses 16'h0000 and 16'hFFFE.
- irq_req deasserting mid-sequence does not abort; the latched idx is serviced and acked.
- A new or higher request arriving mid-sequence waits for IDLE and the next grant condition.
- The outputs are registered-state decodes: mem_*, cpu_hold, and the write strobes are combinational from state, latched data, and mem_rdy.

## Timing
- Reset (rst low, asynchronous): state IDLE; latches 0; all outputs 0.
- Grant cycle: cpu_hold still 0; cpu_hold=1 from the next cycle.
- With mem_rdy tied high, the sequence is 3 cycles after grant (PUSH_PC, PUSH_SR, READ_VEC). cpu_hold falls on the cycle after irq_ack.
- Each memory wait state adds exactly one cycle to that state. Address, data, and request stay stable until mem_rdy.
- Back-to-back grant: IDLE with the grant condition true on the cycle after return grants immediately. The sequencer's own SR write clears GIE, so this requires the control unit to set GIE again.
- rst asserted mid-sequence: immediate IDLE with no further strobes. Partial SP/memory updates already performed stand.

## Configuration
- IRQ_NMI_EN defined:
  - Adds input nmi (1 bit), edge-detected on its rising edge into a pending flag.
  - The flag is granted at instr_boundary regardless of GIE and has priority over all irq_req.
  - Vector address is 16'hFFFC.
  - The flag is cleared at the READ_VEC mem_rdy, with no irq_ack pulse.
  - An nmi edge arriving while its own sequence runs re-pends.
- Undefined: no nmi port; only maskable requests exist.

## Test plan
- Basic entry:
  - Stimulus: mem_rdy=1, pc=16'h4400, sp=16'h0A00, sr=16'h0008, irq_req[3]=1, vector rdata=16'hC123.
  - Response: writes 16'h4400@16'h09FE and 16'h0008@16'h09FC. sp_next is 16'h09FE then 16'h09FC, sr_next=16'h0000, vector read @16'hFFE6, pc_next=16'hC122, irq_ack=8'h08. cpu_hold is high for exactly 3 cycles.
- Priority and mask:
  - Stimulus: irq_req=8'h22 with GIE=1.
  - Response: index 5 serviced, vector @16'hFFEA. The same stimulus with GIE=0 gives no grant and cpu_hold=0.
- Wait states: mem_rdy low for 2 cycles in each state -> sequence takes 9 cycles; mem_addr/mem_wdata unchanged during the waits.
- Wrap and deassert:
  - Stimulus: sp=16'h0002; irq_req drops during PUSH_SR.
  - Response: pushes @16'h0000 and @16'hFFFE; sequence completes and acks the original index.
- Reset mid-sequence: rst low during PUSH_SR -> all outputs 0 in the same cycle; after release no strobes until a new grant.
- IRQ_NMI_EN:
  - Stimulus: nmi rising edge with GIE=0 and irq_req[7]=1.
  - Response: NMI serviced first (vector @16'hFFFC, no ack); then irq 7 is granted only after GIE is set again.
